alu_issue_stage: RTL and testbench

Decode/issue pipeline stage that drives the ALU's operand and operation inputs (op1, op2, alu_op) for the RV32I core. It decodes one instruction per handshake, generates the immediate, and selects the operands. All ALU inputs and execute-side control are registered, with valid/ready flow control, stall and flush.

---
 rtl/riscv_alu_pkg.sv | 65 ++++++
 rtl/alu_issue_stage_if.sv | 34 +++
 rtl/alu_issue_stage_imm_gen.sv | 13 +
 rtl/alu_issue_stage.sv | 149 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared RV32I ALU encodings, opcode/funct constants and the issued-bundle type.
// Combinational helpers only; used by the issue stage and the ALU.
package riscv_alu_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0011;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_XOR = 4'b1101;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SR      = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu_op;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } ex_bundle_t;

    // alt selects SUB/SRA; SLTU has no ALU op here and is rejected by the caller.
    function automatic logic [3:0] funct3_aluop(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            FUNCT3_ADD_SUB: op = alt ? ALUOP_SUB : ALUOP_ADD;
            FUNCT3_SLL:     op = ALUOP_SLL;
            FUNCT3_SLT:     op = ALUOP_SLT;
            FUNCT3_XOR:     op = ALUOP_XOR;
            FUNCT3_SR:      op = alt ? ALUOP_SRA : ALUOP_SRL;
            FUNCT3_OR:      op = ALUOP_OR;
            FUNCT3_AND:     op = ALUOP_AND;
            default:        op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side request and execute-side issued bundle of the ALU issue stage.
// slave = the stage itself, master = whatever drives it.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, ex_ready,
        output in_ready, ex_valid, op1, op2, alu_op, store_data, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, ex_ready,
        input  in_ready, ex_valid, op1, op2, alu_op, store_data, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );
endinterface

// File: rtl/alu_issue_stage_imm_gen.sv
// RV32I immediate extraction (I, S, U, shamt); purely combinational, no state.
module imm_gen (
    input  logic [31:7] instr_i,
    output logic [31:0] immi_o,
    output logic [31:0] imms_o,
    output logic [31:0] immu_o,
    output logic [31:0] shamt_o
);
    assign immi_o  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imms_o  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign immu_o  = {instr_i[31:12], 12'b0};
    assign shamt_o = {27'b0, instr_i[24:20]};
endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: registers ALU operands, alu_op and execute controls.
// One-cycle latency; in_ready = !ex_valid || ex_ready, stalls hold every output, flush kills.
module alu_issue_stage
    import riscv_alu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_OP = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_issue_stage_if.slave bus
);
    localparam ex_bundle_t RST_BUNDLE = '{
        op1: RESET_PC_OP, op2: RESET_PC_OP, alu_op: 4'b0000, store_data: 32'b0,
        rd: 5'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        branch: 1'b0, illegal: 1'b0
    };

    logic [31:0] immi, imms, immu, shamt;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        writes_rd, legal, load;
    ex_bundle_t  dec, bun_d, bun_q;
    logic        vld_d, vld_q;

    imm_gen u_imm_gen (
        .instr_i (bus.instr[31:7]),
        .immi_o  (immi),
        .imms_o  (imms),
        .immu_o  (immu),
        .shamt_o (shamt)
    );

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    always_comb begin
        dec            = RST_BUNDLE;
        dec.op1        = bus.rs1_data;
        dec.op2        = bus.rs2_data;
        dec.alu_op     = ALUOP_ADD;
        dec.store_data = bus.rs2_data;
        dec.rd         = bus.instr[11:7];
        writes_rd      = 1'b0;
        legal          = 1'b1;
        case (opcode)
            OPCODE_OP: begin
                writes_rd  = 1'b1;
                dec.alu_op = funct3_aluop(funct3, funct7 == FUNCT7_ALT);
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                legal = (funct3 != FUNCT3_SLTU) &&
                        ((funct7 == FUNCT7_BASE) ||
                         ((funct7 == FUNCT7_ALT) &&
                          (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SR)));
            end
            OPCODE_OPIMM: begin
                writes_rd  = 1'b1;
                dec.op2    = immi;
                dec.alu_op = funct3_aluop(funct3, (funct3 == FUNCT3_SR) && (funct7 == FUNCT7_ALT));
                legal      = (funct3 != FUNCT3_SLTU);
                if (funct3 == FUNCT3_SLL) begin
                    dec.op2 = shamt;
                    legal   = (funct7 == FUNCT7_BASE);
                end else if (funct3 == FUNCT3_SR) begin
                    dec.op2 = shamt;
                    legal   = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                end
            end
            OPCODE_LOAD: begin
                writes_rd    = 1'b1;
                dec.op2      = immi;
                dec.mem_read = 1'b1;
            end
            OPCODE_STORE: begin
                dec.op2       = imms;
                dec.mem_write = 1'b1;
            end
            OPCODE_BRANCH: begin
                dec.alu_op = ALUOP_SUB;
                dec.branch = 1'b1;
            end
            OPCODE_LUI: begin
                writes_rd = 1'b1;
                dec.op1   = 32'b0;
                dec.op2   = immu;
            end
            OPCODE_AUIPC: begin
                writes_rd = 1'b1;
                dec.op1   = bus.pc;
                dec.op2   = immu;
            end
            OPCODE_JAL: begin
                writes_rd = 1'b1;
                dec.op1   = bus.pc;
                dec.op2   = 32'd4;
            end
            default: legal = 1'b0;
        endcase
        // Illegal instructions still issue so the exception retires in order.
        if (!legal) begin
            dec.alu_op    = ALUOP_ADD;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.illegal   = 1'b1;
        end
        dec.reg_write = writes_rd && legal && (bus.instr[11:7] != 5'd0);
    end

    assign bus.in_ready = !vld_q || bus.ex_ready;
    assign load         = bus.in_valid && bus.in_ready;

    always_comb begin
        vld_d = vld_q;
        bun_d = bun_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            bun_d = dec;
        end else if (bus.ex_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            bun_q <= RST_BUNDLE;
        end else begin
            vld_q <= vld_d;
            bun_q <= bun_d;
        end
    end

    assign bus.ex_valid   = vld_q;
    assign bus.op1        = bun_q.op1;
    assign bus.op2        = bun_q.op2;
    assign bus.alu_op     = bun_q.alu_op;
    assign bus.store_data = bun_q.store_data;
    assign bus.rd         = bun_q.rd;
    assign bus.reg_write  = bun_q.reg_write;
    assign bus.mem_read   = bun_q.mem_read;
    assign bus.mem_write  = bun_q.mem_write;
    assign bus.branch     = bun_q.branch;
    assign bus.illegal    = bun_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage against an instruction-level reference model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.RESET_PC_OP(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] op1, op2, sd;
        logic [3:0]  aop;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ill;
        bit          ops_known;
    } exp_t;

    exp_t m;
    logic m_vld;

    function automatic exp_t reset_exp();
        exp_t e;
        e.op1 = 32'h0; e.op2 = 32'h0; e.sd = 32'h0; e.aop = 4'h0; e.rd = 5'h0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 0; e.ops_known = 1;
        return e;
    endfunction

    // Architectural meaning of one instruction, written mnemonic by mnemonic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [3:0] base_tab [8];
        logic [6:0] f7;
        logic [2:0] f3;
        logic [31:0] imm_i, imm_s, imm_u;
        bit wb, ok, shift;
        base_tab = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
        f7 = ins[31:25];
        f3 = ins[14:12];
        imm_i = 32'(signed'(ins[31:20]));
        imm_s = 32'(signed'({ins[31:25], ins[11:7]}));
        imm_u = ins & 32'hFFFF_F000;
        e = reset_exp();
        e.rd = ins[11:7]; e.sd = r2; e.aop = 4'b0010; e.op1 = r1; e.op2 = r2;
        wb = 0; ok = 1;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        case (ins[6:0])
            7'h33: begin
                wb = 1;
                e.aop = base_tab[f3];
                if (f3 == 3'd3) ok = 0;
                else if (f7 == 7'h20 && f3 == 3'd0) e.aop = 4'b0011;
                else if (f7 == 7'h20 && f3 == 3'd5) e.aop = 4'b1010;
                else if (f7 != 7'h00) ok = 0;
            end
            7'h13: begin
                wb = 1;
                e.aop = base_tab[f3];
                e.op2 = shift ? {27'd0, ins[24:20]} : imm_i;
                if (f3 == 3'd3) ok = 0;
                else if (shift && f7 == 7'h20 && f3 == 3'd5) e.aop = 4'b1010;
                else if (shift && f7 != 7'h00) ok = 0;
            end
            7'h03: begin wb = 1; e.op2 = imm_i; e.mr = 1; end
            7'h23: begin e.op2 = imm_s; e.mw = 1; end
            7'h63: begin e.aop = 4'b0011; e.br = 1; end
            7'h37: begin wb = 1; e.op1 = 0; e.op2 = imm_u; end
            7'h17: begin wb = 1; e.op1 = pc; e.op2 = imm_u; end
            7'h6F: begin wb = 1; e.op1 = pc; e.op2 = 4; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.ill = 1; e.aop = 4'b0010; e.mr = 0; e.mw = 0; e.br = 0; e.ops_known = 0;
        end
        e.rw = wb && ok && (ins[11:7] != 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", bus.ex_valid, m_vld);
        if (m.ops_known) begin
            chk("op1", bus.op1, m.op1);
            chk("op2", bus.op2, m.op2);
        end
        chk("alu_op", bus.alu_op, m.aop);
        chk("store_data", bus.store_data, m.sd);
        chk("rd", bus.rd, m.rd);
        chk("reg_write", bus.reg_write, m.rw);
        chk("mem_read", bus.mem_read, m.mr);
        chk("mem_write", bus.mem_write, m.mw);
        chk("branch", bus.branch, m.br);
        chk("illegal", bus.illegal, m.ill);
    endtask

    // Called at a negedge: drive, check in_ready, advance model at posedge, check at next negedge.
    task automatic step(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic iv, input logic er, input logic fl);
        logic accept;
        bus.instr = ins; bus.pc = p; bus.rs1_data = r1; bus.rs2_data = r2;
        bus.in_valid = iv; bus.ex_ready = er; flush = fl;
        #1;
        chk("in_ready", bus.in_ready, !m_vld || er);
        accept = iv && (!m_vld || er);
        @(posedge clk);
        if (fl) m_vld = 0;
        else if (accept) begin m_vld = 1; m = ref_decode(ins, p, r1, r2); end
        else if (er) m_vld = 0;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10];
        logic [6:0] f7;
        int sel;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h67};
        sel = $urandom_range(0, 3);
        f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                opcs[$urandom_range(0, 9)]};
    endfunction

    initial begin
        bus.in_valid = 0; bus.ex_ready = 0; bus.instr = 0; bus.pc = 0;
        bus.rs1_data = 0; bus.rs2_data = 0;
        m = reset_exp();
        m_vld = 0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        step(32'h00500093, 32'h100, 32'd0, 32'd0, 1, 1, 0);
        chk("addi_ex_valid", bus.ex_valid, 1);
        chk("addi_op2", bus.op2, 32'd5);
        chk("addi_alu_op", bus.alu_op, 4'b0010);
        chk("addi_rd", bus.rd, 5'd1);
        chk("addi_reg_write", bus.reg_write, 1);

        step(32'h402081B3, 32'h104, 32'd10, 32'd3, 1, 1, 0);
        chk("sub_op1", bus.op1, 32'd10);
        chk("sub_op2", bus.op2, 32'd3);
        chk("sub_alu_op", bus.alu_op, 4'b0011);

        step(32'h40335293, 32'h108, 32'h80000000, 32'd0, 1, 1, 0);
        chk("srai_op2", bus.op2, 32'd3);
        chk("srai_alu_op", bus.alu_op, 4'b1010);

        step(32'h0020A423, 32'h10C, 32'h1000, 32'hDEADBEEF, 1, 1, 0);
        chk("sw_op2", bus.op2, 32'd8);
        chk("sw_mem_write", bus.mem_write, 1);
        chk("sw_reg_write", bus.reg_write, 0);
        chk("sw_store_data", bus.store_data, 32'hDEADBEEF);

        step(32'h0020B1B3, 32'h110, 32'd1, 32'd2, 1, 1, 0);
        chk("sltu_illegal", bus.illegal, 1);
        chk("sltu_reg_write", bus.reg_write, 0);

        for (int i = 0; i < 3; i++) begin
            step(32'h123453B7, 32'h114, 32'd7, 32'd9, 1, 0, 0);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_illegal_held", bus.illegal, 1);
        end
        step(32'h123453B7, 32'h114, 32'd7, 32'd9, 1, 1, 0);
        chk("lui_op2", bus.op2, 32'h12345000);
        chk("lui_illegal", bus.illegal, 0);

        step(32'h00500093, 32'h118, 32'd0, 32'd0, 1, 1, 1);
        chk("flush_ex_valid", bus.ex_valid, 0);

        for (int i = 0; i < 300; i++) begin
            step(rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        step(32'h00A00113, 32'h200, 32'd0, 32'd0, 1, 1, 0);
        step(32'h00B00193, 32'h204, 32'd0, 32'd0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        m = reset_exp();
        m_vld = 0;
        chk("arst_ex_valid", bus.ex_valid, 0);
        chk("arst_op1", bus.op1, 32'd0);
        chk("arst_op2", bus.op2, 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h00000013, 32'h0, 32'd0, 32'd0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
